// File: rtl/alu_result_stage.sv
// Registered output stage of the 3-bit ALU: selects the opcode's result, tags it
// with zero/wide flags, buffers it in a 2-entry FIFO and counts delivered results.
module alu_result_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       opcode,
    input  logic [5:0]       add_out,
    input  logic [5:0]       sub_out,
    input  logic [5:0]       mult_out,
    input  logic [5:0]       bw_out,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [5:0]       result,
    output logic [1:0]       result_op,
    output logic             zero,
    output logic             wide,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] result_cnt
);

    localparam int unsigned RES_W = 6;
    localparam int unsigned OCC_W = 2;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef struct packed {
        logic             wide;
        logic             zero;
        logic [1:0]       op;
        logic [RES_W-1:0] res;
    } entry_t;

    entry_t           mem_q [2];
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [RES_W-1:0] sel_c;
    entry_t           entry_c;
    entry_t           head_c;
    logic             push_c;
    logic             pop_c;

    // Operation select and entry tagging; flags are fixed at push time.
    always_comb begin
        sel_c = add_out;
        unique case (opcode)
            2'b00:   sel_c = add_out;
            2'b01:   sel_c = sub_out;
            2'b10:   sel_c = mult_out;
            default: sel_c = bw_out;
        endcase
        entry_c.res  = sel_c;
        entry_c.op   = opcode;
        entry_c.zero = (sel_c == '0);
        entry_c.wide = (sel_c[5:3] != 3'b000);
    end

    // Handshake status depends only on registered occupancy.
    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != '0);
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        cnt_d = cnt_q;
        if (push_c) begin
            wr_d = ~wr_q;
        end
        if (pop_c) begin
            rd_d  = ~rd_q;
            cnt_d = cnt_q + CNT_W'(1);
        end
        unique case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage is cleared with the pointers so outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_q] <= entry_c;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_c     = mem_q[rd_q];
    assign result     = head_c.res;
    assign result_op  = head_c.op;
    assign zero       = head_c.zero;
    assign wide       = head_c.wide;
    assign result_cnt = cnt_q;

endmodule
